// File: rtl/f1_light_seq.sv
// rtl/f1_light_seq.sv - F1 start-light sequencer and reaction timer
// Optional jump-start detection is enabled with `define F1_JUMPSTART_EN.
module f1_light_seq #(
  parameter int WIDTH   = 8,
  parameter int DELAY_W = 7,
  parameter int RT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               trigger,
  input  logic [DELAY_W-1:0] delay,
  input  logic               react,
  output logic [WIDTH-1:0]   data_out,
  output logic               go,
  output logic               busy,
  output logic               rt_valid,
  output logic [RT_W-1:0]    rt_cycles,
  output logic               jump
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_TIME = 2'd3;

  localparam logic [WIDTH-1:0] ALL_ON = '1;
  localparam logic [RT_W-1:0]  RT_MAX = '1;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               go_q, go_d;
  logic               rt_valid_q, rt_valid_d;
  logic [RT_W-1:0]    rt_cycles_q, rt_cycles_d;
  logic [RT_W-1:0]    rt_cnt_q, rt_cnt_d;
  logic [DELAY_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [WIDTH-1:0]   data_shift;
  logic               abort;

  assign data_shift = {data_q[WIDTH-2:0], 1'b1};

`ifdef F1_JUMPSTART_EN
  logic jump_q, jump_d;

  // A reaction while the lights are still building or holding is a jump start.
  assign abort = react && ((state_q == S_FILL) || (state_q == S_HOLD));

  always_comb begin
    jump_d = jump_q;
    if ((state_q == S_IDLE) && trigger) begin
      jump_d = 1'b0;
    end else if (abort) begin
      jump_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      jump_q <= 1'b0;
    end else begin
      jump_q <= jump_d;
    end
  end

  assign jump = jump_q;
`else
  assign abort = 1'b0;
  assign jump  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    go_d        = 1'b0;
    rt_valid_d  = rt_valid_q;
    rt_cycles_d = rt_cycles_q;
    rt_cnt_d    = rt_cnt_q;
    hold_cnt_d  = hold_cnt_q;

    case (state_q)
      S_IDLE: begin
        data_d = '0;
        if (trigger) begin
          state_d    = S_FILL;
          rt_valid_d = 1'b0;
        end
      end
      S_FILL: begin
        if (abort) begin
          state_d    = S_IDLE;
          data_d     = '0;
          rt_valid_d = 1'b0;
        end else if (en) begin
          data_d = data_shift;
          if (data_shift == ALL_ON) begin
            state_d    = S_HOLD;
            hold_cnt_d = delay;
          end
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_d    = S_IDLE;
          data_d     = '0;
          rt_valid_d = 1'b0;
        end else if (en) begin
          if (hold_cnt_q == '0) begin
            state_d  = S_TIME;
            data_d   = '0;
            go_d     = 1'b1;
            rt_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q - 1'b1;
          end
        end
      end
      default: begin
        // The go cycle is the first timed cycle, so a react there reports zero.
        if (react) begin
          state_d     = S_IDLE;
          rt_cycles_d = rt_cnt_q;
          rt_valid_d  = 1'b1;
        end else if (rt_cnt_q != RT_MAX) begin
          rt_cnt_d = rt_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      go_q        <= 1'b0;
      rt_valid_q  <= 1'b0;
      rt_cycles_q <= '0;
      rt_cnt_q    <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      go_q        <= go_d;
      rt_valid_q  <= rt_valid_d;
      rt_cycles_q <= rt_cycles_d;
      rt_cnt_q    <= rt_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign data_out  = data_q;
  assign go        = go_q;
  assign busy      = (state_q != S_IDLE);
  assign rt_valid  = rt_valid_q;
  assign rt_cycles = rt_cycles_q;

endmodule

// File: tb/tb_f1_light_seq.sv
// tb/tb_f1_light_seq.sv - randomized run-level check of f1_light_seq against a start-sequence model
module tb_f1_light_seq;
  localparam int WIDTH   = 8;
  localparam int DELAY_W = 7;
  localparam int RT_W    = 16;
  localparam int RT_SAT  = (1 << RT_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               trigger;
  logic [DELAY_W-1:0] delay;
  logic               react;
  logic [WIDTH-1:0]   data_out;
  logic               go;
  logic               busy;
  logic               rt_valid;
  logic [RT_W-1:0]    rt_cycles;
  logic               jump;

  int checks = 0;
  int failures = 0;
  int go_seen = 0;
  int go_double = 0;
  int go_expected = 0;
  logic go_prev = 1'b0;

  always #5 clk = ~clk;

  f1_light_seq #(.WIDTH(WIDTH), .DELAY_W(DELAY_W), .RT_W(RT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .trigger(trigger), .delay(delay), .react(react),
    .data_out(data_out), .go(go), .busy(busy), .rt_valid(rt_valid),
    .rt_cycles(rt_cycles), .jump(jump)
  );

  always @(negedge clk) begin
    if (go) go_seen++;
    if (go && go_prev) go_double++;
    go_prev = go;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lights lit after k fill ticks: the lowest k bits set.
  function automatic logic [31:0] bar(input int k);
    return (32'd1 << k) - 32'd1;
  endfunction

  task automatic start_run(input int d);
    delay   = DELAY_W'(d);
    trigger = 1'b1;
`ifndef F1_JUMPSTART_EN
    react   = 1'($urandom);
`endif
    step();
    trigger = 1'b0;
    react   = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_rt_valid", 32'(rt_valid), 32'd0);
    chk("start_jump", 32'(jump), 32'd0);
    chk("start_bar", 32'(data_out), 32'd0);
  endtask

  task automatic fill(input int period, input int ticks);
    for (int k = 1; k <= ticks; k++) begin
      repeat (period - 1) begin
        trigger = 1'($urandom);
        step();
      end
      trigger = 1'b0;
      en = 1'b1;
      step();
      en = 1'b0;
      chk("fill_bar", 32'(data_out), bar(k));
    end
  endtask

  task automatic run(input int d, input int n, input int period, input bit early_react);
    start_run(d);
    fill(period, WIDTH);
    delay = DELAY_W'($urandom);
    for (int j = 1; j <= d + 1; j++) begin
      repeat (period - 1) step();
      if (early_react) react = 1'b1;
      en = 1'b1;
      step();
      en = 1'b0;
      if (j <= d) begin
        chk("hold_bar", 32'(data_out), bar(WIDTH));
        chk("hold_go", 32'(go), 32'd0);
      end else begin
        chk("out_bar", 32'(data_out), 32'd0);
        chk("out_go", 32'(go), 32'd1);
        chk("out_busy", 32'(busy), 32'd1);
        go_expected++;
      end
    end
    repeat (n) begin
      en = 1'($urandom);
      step();
    end
    en = 1'b0;
    react = 1'b1;
    step();
    react = 1'b0;
    chk("rt_valid", 32'(rt_valid), 32'd1);
    chk("rt_cycles", 32'(rt_cycles), 32'((n < RT_SAT) ? n : RT_SAT));
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_bar", 32'(data_out), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; trigger = 1'b0; react = 1'b0; delay = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_bar", 32'(data_out), 32'd0);
    chk("rst_go", 32'(go), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rt_valid", 32'(rt_valid), 32'd0);
    chk("rst_rt_cycles", 32'(rt_cycles), 32'd0);
    chk("rst_jump", 32'(jump), 32'd0);

    run(3, 37, 4, 1'b0);
`ifndef F1_JUMPSTART_EN
    run(int'($urandom_range(0, 5)), 0, 4, 1'b1);
`endif
    for (int r = 0; r < 12; r++) begin
      run(int'($urandom_range(0, 6)), int'($urandom_range(0, 200)),
          int'($urandom_range(1, 4)), 1'b0);
    end
    run(0, 70000, 1, 1'b0);
    run(0, 1, 4, 1'b0);

    // Reset while the lights are held on.
    start_run(3);
    fill(4, WIDTH);
    en = 1'b1;
    step();
    en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_bar", 32'(data_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_go", 32'(go), 32'd0);
    chk("midrst_rt_valid", 32'(rt_valid), 32'd0);
    chk("midrst_rt_cycles", 32'(rt_cycles), 32'd0);
    repeat (12) begin
      en = 1'b1;
      step();
      en = 1'b0;
      chk("midrst_stay_idle", 32'(data_out), 32'd0);
    end

    // React coincident with a fill tick at three lights.
    start_run(2);
    fill(4, 3);
    en = 1'b1;
    react = 1'b1;
    step();
    en = 1'b0;
    react = 1'b0;
`ifdef F1_JUMPSTART_EN
    chk("js_bar", 32'(data_out), 32'd0);
    chk("js_jump", 32'(jump), 32'd1);
    chk("js_busy", 32'(busy), 32'd0);
    chk("js_rt_valid", 32'(rt_valid), 32'd0);
    repeat (20) step();
    chk("js_jump_held", 32'(jump), 32'd1);
    start_run(0);
    fill(1, WIDTH);
    en = 1'b1;
    step();
    en = 1'b0;
    chk("js_next_go", 32'(go), 32'd1);
    go_expected++;
    react = 1'b1;
    step();
    react = 1'b0;
    chk("js_next_rt", 32'(rt_cycles), 32'd0);
`else
    chk("nojs_bar", 32'(data_out), bar(4));
    chk("nojs_jump", 32'(jump), 32'd0);
    chk("nojs_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
`endif

    repeat (3) step();
    chk("go_pulses", 32'(go_seen), 32'(go_expected));
    chk("go_double", 32'(go_double), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
